// File: rtl/mem_ctrl_pkg.sv
// Shared types for the memory-controller request queue: slot and issue-FSM
// encodings plus the packet-type codes used downstream for ID/type tagging.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    SLOT_FREE   = 2'd0,
    SLOT_PEND   = 2'd1,
    SLOT_ISSUED = 2'd2,
    SLOT_DONE   = 2'd3
  } slot_state_e;

  typedef enum logic [2:0] {
    IS_IDLE    = 3'd0,
    IS_RD_GO   = 3'd1,
    IS_RD_DATA = 3'd2,
    IS_WR_GO   = 3'd3,
    IS_WR_PUSH = 3'd4,
    IS_WR_WAIT = 3'd5
  } issue_state_e;

  localparam logic [2:0] PKT_WR_ACK  = 3'b101;
  localparam logic [2:0] PKT_RD_RESP = 3'b110;

endpackage

// File: rtl/mem_ctrl_resp_serializer.sv
// Splits a completed line into BEAT_W-wide response beats (lowest bits first).
// Handshake: a beat transfers on resp_valid & resp_ready; while stalled every resp_* output holds.
module mem_ctrl_resp_serializer
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W = 36,
  parameter int LINE_W = 512,
  parameter int BEAT_W = 512,
  parameter int ID_W   = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid,
  input  logic              i_we,
  input  logic [ID_W-1:0]   i_id,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [LINE_W-1:0] i_line,
  output logic              o_retire,
  output logic              o_resp_valid,
  input  logic              i_resp_ready,
  output logic              o_resp_we,
  output logic [ID_W-1:0]   o_resp_id,
  output logic [ADDR_W-1:0] o_resp_addr,
  output logic [BEAT_W-1:0] o_resp_data,
  output logic              o_resp_last
);

  localparam int NBEATS = LINE_W / BEAT_W;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(NBEATS - 1);

  logic [CNT_W-1:0]  r_beat;
  logic [BEAT_W-1:0] w_beat_data;
  logic              w_last;
  logic              w_fire;

  always_comb begin
    w_beat_data = '0;
    for (int k = 0; k < NBEATS; k++) begin
      if (r_beat == CNT_W'(k)) w_beat_data = i_line[k*BEAT_W +: BEAT_W];
    end
  end

  // Write acks are always a single beat regardless of the line/beat ratio.
  assign w_last   = i_we | (r_beat == LAST_BEAT);
  assign w_fire   = i_valid & i_resp_ready;
  assign o_retire = w_fire & w_last;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         r_beat <= '0;
    else if (w_fire) r_beat <= w_last ? '0 : r_beat + CNT_W'(1);
  end

  assign o_resp_valid = i_valid;
  assign o_resp_we    = i_valid & i_we;
  assign o_resp_id    = i_valid ? i_id : '0;
  assign o_resp_addr  = i_valid ? (i_addr + ADDR_W'(r_beat) * ADDR_W'(BEAT_W / 8)) : '0;
  assign o_resp_data  = (i_valid & ~i_we) ? w_beat_data : '0;
  assign o_resp_last  = i_valid & w_last;

endmodule

// File: rtl/mem_ctrl_queue.sv
// In-order request queue between the core request port and the host DMA engines.
// Optional performance counters are built only when MEM_CTRL_QUEUE_PERF_EN is defined.
module mem_ctrl_queue
  import mem_ctrl_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int ADDR_W  = 36,
  parameter int LINE_W  = 512,
  parameter int BEAT_W  = 512,
  parameter int ID_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [LINE_W-1:0] req_data,
  input  logic [ID_W-1:0]   req_id,
  output logic              rd_go,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_empty,
  output logic              rd_en,
  input  logic [LINE_W-1:0] rd_data,
  input  logic              rd_done,
  output logic              wr_go,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [LINE_W-1:0] wr_data,
  input  logic              wr_full,
  output logic              wr_en,
  input  logic              wr_done,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_we,
  output logic [ID_W-1:0]   resp_id,
  output logic [ADDR_W-1:0] resp_addr,
  output logic [BEAT_W-1:0] resp_data,
  output logic              resp_last,
  output logic [31:0]       perf_rd_cnt,
  output logic [31:0]       perf_wr_cnt,
  output logic [31:0]       perf_stall_cnt
);

  localparam int PTR_W = $clog2(ENTRIES);
  localparam int CNT_W = PTR_W + 1;

  slot_state_e       r_slot_st   [ENTRIES];
  logic              r_slot_we   [ENTRIES];
  logic [ADDR_W-1:0] r_slot_addr [ENTRIES];
  logic [LINE_W-1:0] r_slot_data [ENTRIES];
  logic [ID_W-1:0]   r_slot_id   [ENTRIES];

  logic [PTR_W-1:0] r_alloc_ptr, r_issue_ptr, r_resp_ptr;
  logic [CNT_W-1:0] r_count;
  issue_state_e     r_state, w_next;
  logic             r_popped;

  logic w_alloc, w_retire, w_set_issued, w_set_done, w_cap;

  assign req_ready = (r_count != CNT_W'(ENTRIES));
  assign w_alloc   = req_valid & req_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_alloc_ptr <= '0;
      r_issue_ptr <= '0;
      r_resp_ptr  <= '0;
      r_count     <= '0;
      r_state     <= IS_IDLE;
      r_popped    <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_alloc)    r_alloc_ptr <= r_alloc_ptr + PTR_W'(1);
      if (w_set_done) r_issue_ptr <= r_issue_ptr + PTR_W'(1);
      if (w_retire)   r_resp_ptr  <= r_resp_ptr + PTR_W'(1);
      case ({w_alloc, w_retire})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
      if (r_state == IS_RD_GO)        r_popped <= 1'b0;
      else if (w_cap)                 r_popped <= 1'b1;
    end
  end

  // Alloc, issue and response pointers always address slots in distinct states,
  // so these updates never collide on one slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) r_slot_st[i] <= SLOT_FREE;
    end else begin
      if (w_alloc)      r_slot_st[r_alloc_ptr] <= SLOT_PEND;
      if (w_set_issued) r_slot_st[r_issue_ptr] <= SLOT_ISSUED;
      if (w_set_done)   r_slot_st[r_issue_ptr] <= SLOT_DONE;
      if (w_retire)     r_slot_st[r_resp_ptr]  <= SLOT_FREE;
    end
  end

  always_ff @(posedge clk) begin
    if (w_alloc) begin
      r_slot_we[r_alloc_ptr]   <= req_we;
      r_slot_addr[r_alloc_ptr] <= req_addr;
      r_slot_data[r_alloc_ptr] <= req_data;
      r_slot_id[r_alloc_ptr]   <= req_id;
    end
    if (w_cap) r_slot_data[r_issue_ptr] <= rd_data;
  end

  always_comb begin
    w_next       = r_state;
    rd_go        = 1'b0;
    rd_en        = 1'b0;
    wr_go        = 1'b0;
    wr_en        = 1'b0;
    w_set_issued = 1'b0;
    w_set_done   = 1'b0;
    w_cap        = 1'b0;
    case (r_state)
      IS_IDLE: begin
        if (r_slot_st[r_issue_ptr] == SLOT_PEND)
          w_next = r_slot_we[r_issue_ptr] ? IS_WR_GO : IS_RD_GO;
      end
      IS_RD_GO: begin
        rd_go        = 1'b1;
        w_set_issued = 1'b1;
        w_next       = IS_RD_DATA;
      end
      IS_RD_DATA: begin
        rd_en = ~rd_empty;
        w_cap = ~rd_empty;
        // A pop in the same cycle as rd_done still counts as the data beat.
        if (rd_done && (r_popped || !rd_empty)) begin
          w_set_done = 1'b1;
          w_next     = IS_IDLE;
        end
      end
      IS_WR_GO: begin
        wr_go        = 1'b1;
        w_set_issued = 1'b1;
        w_next       = IS_WR_PUSH;
      end
      IS_WR_PUSH: begin
        wr_en = ~wr_full;
        if (!wr_full) w_next = IS_WR_WAIT;
      end
      IS_WR_WAIT: begin
        if (wr_done) begin
          w_set_done = 1'b1;
          w_next     = IS_IDLE;
        end
      end
      default: w_next = IS_IDLE;
    endcase
  end

  assign rd_addr = (r_state == IS_RD_GO || r_state == IS_RD_DATA) ? r_slot_addr[r_issue_ptr] : '0;
  assign wr_addr = (r_state == IS_WR_GO || r_state == IS_WR_PUSH || r_state == IS_WR_WAIT)
                   ? r_slot_addr[r_issue_ptr] : '0;
  assign wr_data = (r_state == IS_WR_GO || r_state == IS_WR_PUSH || r_state == IS_WR_WAIT)
                   ? r_slot_data[r_issue_ptr] : '0;

  mem_ctrl_resp_serializer #(
    .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(BEAT_W), .ID_W(ID_W)
  ) u_ser (
    .clk          (clk),
    .rst          (rst),
    .i_valid      (r_slot_st[r_resp_ptr] == SLOT_DONE),
    .i_we         (r_slot_we[r_resp_ptr]),
    .i_id         (r_slot_id[r_resp_ptr]),
    .i_addr       (r_slot_addr[r_resp_ptr]),
    .i_line       (r_slot_data[r_resp_ptr]),
    .o_retire     (w_retire),
    .o_resp_valid (resp_valid),
    .i_resp_ready (resp_ready),
    .o_resp_we    (resp_we),
    .o_resp_id    (resp_id),
    .o_resp_addr  (resp_addr),
    .o_resp_data  (resp_data),
    .o_resp_last  (resp_last)
  );

`ifdef MEM_CTRL_QUEUE_PERF_EN
  logic [31:0] r_perf_rd, r_perf_wr, r_perf_stall;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_perf_rd    <= '0;
      r_perf_wr    <= '0;
      r_perf_stall <= '0;
    end else begin
      if (w_retire && !r_slot_we[r_resp_ptr]) r_perf_rd <= r_perf_rd + 32'd1;
      if (w_retire &&  r_slot_we[r_resp_ptr]) r_perf_wr <= r_perf_wr + 32'd1;
      if (req_valid && !req_ready)            r_perf_stall <= r_perf_stall + 32'd1;
    end
  end

  assign perf_rd_cnt    = r_perf_rd;
  assign perf_wr_cnt    = r_perf_wr;
  assign perf_stall_cnt = r_perf_stall;
`else
  assign perf_rd_cnt    = '0;
  assign perf_wr_cnt    = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mem_ctrl_queue.sv
// Bench for mem_ctrl_queue: wide (512b beat) and narrow (128b beat) instances,
// a host model and a response scoreboard fed by the request driver.
module tb_mem_ctrl_queue;
  import mem_ctrl_pkg::*;

  localparam int ADDR_W = 36;
  localparam int LINE_W = 512;
  localparam int ID_W   = 4;
`ifdef MEM_CTRL_QUEUE_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- wide DUT signals ----------------
  logic req_valid = 0, req_ready, req_we = 0;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [LINE_W-1:0] req_data = '0;
  logic [ID_W-1:0]   req_id = '0;
  logic rd_go, rd_en, rd_empty = 1, rd_done = 0;
  logic [ADDR_W-1:0] rd_addr;
  logic [LINE_W-1:0] rd_data = '0;
  logic wr_go, wr_en, wr_full = 0, wr_done = 0;
  logic [ADDR_W-1:0] wr_addr;
  logic [LINE_W-1:0] wr_data;
  logic resp_valid, resp_ready = 0, resp_we, resp_last;
  logic [ID_W-1:0]   resp_id;
  logic [ADDR_W-1:0] resp_addr;
  logic [LINE_W-1:0] resp_data;
  logic [31:0] perf_rd_cnt, perf_wr_cnt, perf_stall_cnt;

  // ---------------- narrow DUT signals ----------------
  logic n_req_valid = 0, n_req_ready, n_req_we = 0;
  logic [ADDR_W-1:0] n_req_addr = '0;
  logic [LINE_W-1:0] n_req_data = '0;
  logic [ID_W-1:0]   n_req_id = '0;
  logic n_rd_go, n_rd_en, n_rd_empty = 1, n_rd_done = 0;
  logic [ADDR_W-1:0] n_rd_addr;
  logic [LINE_W-1:0] n_rd_data = '0;
  logic n_wr_go, n_wr_en;
  logic [ADDR_W-1:0] n_wr_addr;
  logic [LINE_W-1:0] n_wr_data;
  logic n_resp_valid, n_resp_ready = 0, n_resp_we, n_resp_last;
  logic [ID_W-1:0]   n_resp_id;
  logic [ADDR_W-1:0] n_resp_addr;
  logic [127:0]      n_resp_data;
  logic [31:0] n_perf_rd_cnt, n_perf_wr_cnt, n_perf_stall_cnt;

  mem_ctrl_queue #(.ENTRIES(16), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(512), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_addr(req_addr),
    .req_data(req_data), .req_id(req_id),
    .rd_go(rd_go), .rd_addr(rd_addr), .rd_empty(rd_empty), .rd_en(rd_en), .rd_data(rd_data),
    .rd_done(rd_done),
    .wr_go(wr_go), .wr_addr(wr_addr), .wr_data(wr_data), .wr_full(wr_full), .wr_en(wr_en),
    .wr_done(wr_done),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_we(resp_we), .resp_id(resp_id),
    .resp_addr(resp_addr), .resp_data(resp_data), .resp_last(resp_last),
    .perf_rd_cnt(perf_rd_cnt), .perf_wr_cnt(perf_wr_cnt), .perf_stall_cnt(perf_stall_cnt)
  );

  mem_ctrl_queue #(.ENTRIES(16), .ADDR_W(ADDR_W), .LINE_W(LINE_W), .BEAT_W(128), .ID_W(ID_W)) dut_n (
    .clk(clk), .rst(rst),
    .req_valid(n_req_valid), .req_ready(n_req_ready), .req_we(n_req_we), .req_addr(n_req_addr),
    .req_data(n_req_data), .req_id(n_req_id),
    .rd_go(n_rd_go), .rd_addr(n_rd_addr), .rd_empty(n_rd_empty), .rd_en(n_rd_en),
    .rd_data(n_rd_data), .rd_done(n_rd_done),
    .wr_go(n_wr_go), .wr_addr(n_wr_addr), .wr_data(n_wr_data), .wr_full(1'b0), .wr_en(n_wr_en),
    .wr_done(1'b0),
    .resp_valid(n_resp_valid), .resp_ready(n_resp_ready), .resp_we(n_resp_we),
    .resp_id(n_resp_id), .resp_addr(n_resp_addr), .resp_data(n_resp_data),
    .resp_last(n_resp_last),
    .perf_rd_cnt(n_perf_rd_cnt), .perf_wr_cnt(n_perf_wr_cnt), .perf_stall_cnt(n_perf_stall_cnt)
  );

  // ---------------- scoreboard state ----------------
  typedef struct packed {
    logic              we;
    logic [ID_W-1:0]   id;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] data;
  } txn_t;

  txn_t host_exp_q[$];
  txn_t resp_exp_q[$];
  int errs = 0;
  int checks = 0;
  int unsigned exp_rd = 0, exp_wr = 0, exp_stall = 0;
  bit host_block = 1'b0;
  int host_full_cyc = 0;
  int rr_mode = 0;

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] v;
    v = '0;
    for (int k = 0; k < LINE_W / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // ---------------- host model (wide DUT) ----------------
  initial begin : host_model
    txn_t t;
    bit   have;
    forever begin
      @(negedge clk);
      if (!rst && (rd_go || wr_go)) begin
        have = (host_exp_q.size() != 0);
        t = have ? host_exp_q.pop_front() : '0;
        checks++;
        if (!have || wr_go !== t.we || (rd_go ? rd_addr : wr_addr) !== t.addr) begin
          errs++;
          $display("FAIL host_order: got we=%0d addr=%h, expected we=%0d addr=%h (queued=%0d)",
                   wr_go, rd_go ? rd_addr : wr_addr, t.we, t.addr, have);
        end
        @(negedge clk);
        while (host_block && !rst) @(negedge clk);
        if (!rst && !t.we) begin
          rd_data = t.data;
          rd_empty = 1'b0;
          #1;
          checks++;
          if (rd_en !== 1'b1) begin errs++; $display("FAIL rd_pop: rd_en=%0d, expected 1", rd_en); end
          @(negedge clk);
          rd_empty = 1'b1;
          rd_done = 1'b1;
          @(negedge clk);
          rd_done = 1'b0;
        end else if (!rst) begin
          for (int c = 0; c < host_full_cyc; c++) begin
            wr_full = 1'b1;
            #1;
            checks++;
            if (wr_en !== 1'b0) begin errs++; $display("FAIL wr_full_hold: wr_en=%0d, expected 0", wr_en); end
            @(negedge clk);
          end
          wr_full = 1'b0;
          #1;
          checks++;
          if (wr_en !== 1'b1 || wr_data !== t.data) begin
            errs++;
            $display("FAIL wr_push: wr_en=%0d data=%h, expected 1 data=%h", wr_en, wr_data[63:0], t.data[63:0]);
          end
          @(negedge clk);
          #1;
          checks++;
          if (wr_en !== 1'b0) begin errs++; $display("FAIL wr_single_push: wr_en=%0d, expected 0", wr_en); end
          wr_done = 1'b1;
          @(negedge clk);
          wr_done = 1'b0;
        end
      end
    end
  end

  // ---------------- response monitor (wide DUT) ----------------
  initial begin : resp_mon
    txn_t t;
    forever begin
      @(negedge clk);
      resp_ready = (rr_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      #1;
      if (!rst && resp_valid && resp_ready) begin
        checks++;
        if (resp_exp_q.size() == 0) begin
          errs++;
          $display("FAIL resp_unexpected: id=%0d we=%0d, expected no response", resp_id, resp_we);
        end else begin
          t = resp_exp_q.pop_front();
          if (resp_we !== t.we || resp_id !== t.id || resp_addr !== t.addr || resp_last !== 1'b1 ||
              resp_data !== (t.we ? LINE_W'(0) : t.data)) begin
            errs++;
            $display("FAIL resp_beat: we=%0d id=%0d addr=%h last=%0d data=%h, expected we=%0d id=%0d addr=%h last=1 data=%h",
                     resp_we, resp_id, resp_addr, resp_last, resp_data[63:0],
                     t.we, t.id, t.addr, t.we ? 64'd0 : t.data[63:0]);
          end
          if (t.we) exp_wr++;
          else      exp_rd++;
        end
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic we, input logic [ADDR_W-1:0] addr,
                      input logic [LINE_W-1:0] data, input logic [ID_W-1:0] id);
    int   n;
    txn_t t;
    n = 0;
    req_we = we; req_addr = addr; req_data = data; req_id = id; req_valid = 1'b1;
    #1;
    while (!req_ready && n < 500) begin @(negedge clk); #1; n++; end
    checks++;
    if (n >= 500) begin
      errs++;
      $display("FAIL send_timeout: req_ready=%0d after %0d cycles, expected 1", req_ready, n);
    end else begin
      t.we = we; t.id = id; t.addr = addr; t.data = data;
      host_exp_q.push_back(t);
      resp_exp_q.push_back(t);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string tag);
    int n;
    n = 0;
    while ((resp_exp_q.size() != 0 || host_exp_q.size() != 0) && n < 3000) begin
      @(negedge clk); n++;
    end
    repeat (3) @(negedge clk);
    checks++;
    if (n >= 3000) begin
      errs++;
      $display("FAIL %s_drain: %0d responses outstanding, expected 0", tag, resp_exp_q.size());
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1) begin errs++; $display("FAIL reset_req_ready: got %0d, expected 1", req_ready); end
    checks++;
    if ({rd_go, rd_en, wr_go, wr_en, resp_valid, resp_we, resp_last} !== 7'd0) begin
      errs++; $display("FAIL reset_ctrl: got %b, expected 0000000", {rd_go, rd_en, wr_go, wr_en, resp_valid, resp_we, resp_last});
    end
    checks++;
    if ({rd_addr, wr_addr, resp_addr, resp_id} !== '0 || {wr_data, resp_data} !== '0) begin
      errs++; $display("FAIL reset_data: addr/data outputs nonzero, expected 0");
    end
    checks++;
    if ({perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== 96'd0) begin
      errs++; $display("FAIL reset_perf: got %0d/%0d/%0d, expected 0", perf_rd_cnt, perf_wr_cnt, perf_stall_cnt);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_read();
    int lat;
    send(1'b0, 36'h000001000, {64{8'hAB}}, 4'd3);
    lat = 0;
    #1;
    while (!rd_go && lat < 20) begin @(negedge clk); #1; lat++; end
    checks++;
    if (lat != 1) begin errs++; $display("FAIL read_latency: rd_go after %0d cycles, expected 1", lat); end
    checks++;
    if (rd_addr !== 36'h000001000) begin errs++; $display("FAIL rd_addr: got %h, expected 000001000", rd_addr); end
    @(negedge clk);
    #1;
    checks++;
    if (rd_go !== 1'b0) begin errs++; $display("FAIL rd_go_pulse: got %0d, expected 0", rd_go); end
    wait_drain("single_read");
  endtask

  task automatic test_single_write();
    host_full_cyc = 3;
    send(1'b1, 36'h000002000, {64{8'h55}}, 4'd5);
    wait_drain("single_write");
    host_full_cyc = 0;
  endtask

  task automatic test_mixed();
    rr_mode = 1;
    send(1'b0, 36'h000003000, rand_line(), 4'd1);
    send(1'b1, 36'h000003040, rand_line(), 4'd2);
    send(1'b0, 36'h000003080, rand_line(), 4'd7);
    wait_drain("mixed");
    rr_mode = 0;
  endtask

  task automatic test_fill();
    host_block = 1'b1;
    for (int i = 0; i < 16; i++) begin
      send(1'(i % 2), 36'h000010000 + ADDR_W'(i * 64), rand_line(), ID_W'(i));
      if (i == 14) begin
        #1;
        checks++;
        if (req_ready !== 1'b1) begin errs++; $display("FAIL fill_ready15: got %0d, expected 1", req_ready); end
      end
    end
    #1;
    checks++;
    if (req_ready !== 1'b0) begin errs++; $display("FAIL fill_full: req_ready=%0d, expected 0", req_ready); end
    req_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      checks++;
      if (req_ready !== 1'b0) begin errs++; $display("FAIL fill_stall: req_ready=%0d cycle %0d, expected 0", req_ready, c); end
    end
    req_valid = 1'b0;
    exp_stall += 5;
    host_block = 1'b0;
    wait_drain("fill");
    for (int i = 0; i < 4; i++) send(1'(i == 2), 36'h000020000 + ADDR_W'(i * 64), rand_line(), ID_W'(i));
    wait_drain("wrap");
  endtask

  task automatic test_perf(input string tag);
    checks++;
    if (perf_rd_cnt !== (PERF ? 32'(exp_rd) : 32'd0)) begin
      errs++; $display("FAIL %s_perf_rd: got %0d, expected %0d", tag, perf_rd_cnt, PERF ? exp_rd : 0);
    end
    checks++;
    if (perf_wr_cnt !== (PERF ? 32'(exp_wr) : 32'd0)) begin
      errs++; $display("FAIL %s_perf_wr: got %0d, expected %0d", tag, perf_wr_cnt, PERF ? exp_wr : 0);
    end
    checks++;
    if (perf_stall_cnt !== (PERF ? 32'(exp_stall) : 32'd0)) begin
      errs++; $display("FAIL %s_perf_stall: got %0d, expected %0d", tag, perf_stall_cnt, PERF ? exp_stall : 0);
    end
  endtask

  task automatic test_narrow();
    logic [LINE_W-1:0] line;
    int n, beat, cyc;
    line = rand_line();
    @(negedge clk);
    n_req_we = 1'b0; n_req_addr = 36'h40; n_req_id = 4'd6; n_req_data = '0; n_req_valid = 1'b1;
    @(negedge clk);
    n_req_valid = 1'b0;
    n = 0;
    #1;
    while (!n_rd_go && n < 20) begin @(negedge clk); #1; n++; end
    checks++;
    if (!n_rd_go || n_rd_addr !== 36'h40) begin
      errs++; $display("FAIL narrow_rd_go: go=%0d addr=%h, expected 1 addr=40", n_rd_go, n_rd_addr);
    end
    @(negedge clk);
    n_rd_data = line; n_rd_empty = 1'b0;
    @(negedge clk);
    n_rd_empty = 1'b1; n_rd_done = 1'b1;
    @(negedge clk);
    n_rd_done = 1'b0;
    beat = 0;
    cyc = 0;
    while (beat < 4 && cyc < 60) begin
      n_resp_ready = 1'(cyc % 2);
      #1;
      if (n_resp_valid) begin
        checks++;
        if (n_resp_addr !== 36'h40 + ADDR_W'(beat * 16) || n_resp_data !== line[beat*128 +: 128] ||
            n_resp_last !== (beat == 3) || n_resp_id !== 4'd6 || n_resp_we !== 1'b0) begin
          errs++;
          $display("FAIL narrow_beat%0d: addr=%h last=%0d data=%h, expected addr=%h last=%0d data=%h (ready=%0d)",
                   beat, n_resp_addr, n_resp_last, n_resp_data, 36'h40 + ADDR_W'(beat * 16), beat == 3,
                   line[beat*128 +: 128], n_resp_ready);
        end
        if (n_resp_ready) beat++;
      end
      @(negedge clk);
      cyc++;
    end
    n_resp_ready = 1'b0;
    #1;
    checks++;
    if (beat != 4 || n_resp_valid !== 1'b0) begin
      errs++; $display("FAIL narrow_done: beats=%0d valid=%0d, expected 4 beats then valid 0", beat, n_resp_valid);
    end
  endtask

  task automatic test_reset_mid();
    host_block = 1'b1;
    send(1'b0, 36'h000005000, rand_line(), 4'd9);
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    checks++;
    if (req_ready !== 1'b1 || {rd_go, rd_en, wr_go, wr_en, resp_valid, resp_we, resp_last} !== 7'd0 ||
        {rd_addr, wr_addr, resp_addr, resp_id} !== '0 || {perf_rd_cnt, perf_wr_cnt, perf_stall_cnt} !== 96'd0) begin
      errs++;
      $display("FAIL reset_mid_outputs: ready=%0d ctrl=%b rd_addr=%h, expected ready=1 ctrl=0000000 rd_addr=0",
               req_ready, {rd_go, rd_en, wr_go, wr_en, resp_valid, resp_we, resp_last}, rd_addr);
    end
    resp_exp_q.delete();
    host_exp_q.delete();
    exp_rd = 0; exp_wr = 0; exp_stall = 0;
    host_block = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    send(1'b0, 36'h000006000, rand_line(), 4'd10);
    wait_drain("after_reset");
  endtask

  initial begin : main
    test_reset();
    test_single_read();
    test_single_write();
    test_mixed();
    test_fill();
    test_perf("run");
    test_narrow();
    test_reset_mid();
    test_perf("post_reset");
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/mem_ctrl_queue.md
Name: mem_ctrl_queue

Overview:
- Parametrised, in-order request queue between the cache/core request port and the host DMA read/write engines.
- Accepts line read/write requests tagged with an ID and holds them in a circular slot buffer of ENTRIES slots.
- Issues one host transaction at a time, in order.
- Returns responses in order, serialising read data into BEAT_W-wide beats for narrow clients.

Parameters:
- ENTRIES, 16: slot count; power of two, ≥2.
- ADDR_W, 36: address width.
- LINE_W, 512: host line width.
- BEAT_W, 512: response beat width; LINE_W/BEAT_W is a power of two (1, 2, 4).
- ID_W, 4: request tag width.

Ports:
- clk  in  1  clock
- rst  in  1  async reset, active-high
- req_valid  in  1  request present
- req_ready  out  1  slot free
- req_we  in  1  1=write, 0=read
- req_addr  in  ADDR_W  line address
- req_data  in  LINE_W  write data
- req_id  in  ID_W  tag
- rd_go  out  1  one-cycle start of host read
- rd_addr  out  ADDR_W  host read address
- rd_empty  in  1  host read FIFO empty
- rd_en  out  1  pop host read FIFO
- rd_data  in  LINE_W  host read data
- rd_done  in  1  host read complete
- wr_go  out  1  one-cycle start of host write
- wr_addr  out  ADDR_W  host write address
- wr_data  out  LINE_W  host write data
- wr_full  in  1  host write FIFO full
- wr_en  out  1  push host write FIFO
- wr_done  in  1  host write complete
- resp_valid  out  1  response beat valid
- resp_ready  in  1  consumer accepts beat
- resp_we  out  1  1=write ack, 0=read data
- resp_id  out  ID_W  tag
- resp_addr  out  ADDR_W  beat address (line addr + beat offset)
- resp_data  out  BEAT_W  beat data
- resp_last  out  1  final beat of response
- perf_rd_cnt  out  32  completed reads
- perf_wr_cnt  out  32  completed writes
- perf_stall_cnt  out  32  cycles with req_valid & ~req_ready

Behaviour:
- Reset: async, active-high on rst; clock clk.
  - All outputs 0; pointers 0; all slots FREE; count 0.
  - Reset mid-transaction abandons the slot; no response is produced.
- Slots: circular buffer. Pointers alloc_ptr, issue_ptr, resp_ptr, each $clog2(ENTRIES) bits, wrapping naturally.
  - Slot states: FREE, PEND, ISSUED, DONE.
- Allocate:
  - req_ready = (count != ENTRIES).
  - On req_valid & req_ready: slot[alloc_ptr] <= PEND, capturing we/addr/data/id; alloc_ptr++.
- Issue FSM: IDLE, RD_GO, RD_DATA, WR_GO, WR_PUSH, WR_WAIT.
  - IDLE: if slot[issue_ptr]==PEND, go to RD_GO or WR_GO.
  - RD_GO: assert rd_go with rd_addr for 1 cycle; slot -> ISSUED; go to RD_DATA.
  - RD_DATA: rd_en = ~rd_empty; a pop captures rd_data into the slot that cycle.
    - When rd_done and ≥1 pop has occurred: slot -> DONE, issue_ptr++, go to IDLE.
    - rd_done with pop in the same cycle: capture, then complete.
  - WR_GO: assert wr_go for 1 cycle; go to WR_PUSH.
  - WR_PUSH: wr_en = ~wr_full, holding wr_data for exactly one push; then go to WR_WAIT.
  - WR_WAIT: on wr_done, slot -> DONE, issue_ptr++, go to IDLE.
- Latency: accepted request to rd_go/wr_go is ≥2 cycles (alloc cycle + IDLE decision) when the queue is idle.
- Response:
  - Slot[resp_ptr]==DONE drives resp_* from the serializer.
  - Reads emit LINE_W/BEAT_W beats, lowest bits first; resp_addr increments by BEAT_W/8 per beat.
  - Writes emit a single beat: resp_data=0, resp_last=1.
  - Beat advances on resp_valid & resp_ready; outputs hold stable while stalled.
  - After the last beat: slot -> FREE, resp_ptr++.
- count:
  - +1 on allocate, -1 on final-beat retire.
  - Simultaneous allocate and retire leave count unchanged.
  - Full queue with a same-cycle retire: req_ready stays 0 that cycle (registered count).
- Issue and response proceed concurrently. A slot DONE in cycle N may present resp_valid in cycle N+1.
- Wrap-around: pointer rollover ENTRIES-1 -> 0 has no bubble.

Optional Feature:
- Macro: MEM_CTRL_QUEUE_PERF_EN.
- Defined:
  - perf_rd_cnt increments on read retire.
  - perf_wr_cnt increments on write retire.
  - perf_stall_cnt increments on req_valid & ~req_ready.
  - All are 32-bit, wrap on overflow, and clear on rst.
- Undefined: all three ports tied to 0; no counter flops.

Decomposition:
- Package mem_ctrl_pkg: slot_state_e (FREE/PEND/ISSUED/DONE), issue_state_e, and packet-type constants (PKT_WR_ACK=3'b101, PKT_RD_RESP=3'b110) for downstream ID/type encoding.
- Sub-module mem_ctrl_resp_serializer: LINE_W->BEAT_W beat counter, valid/ready hold, and last generation.

Test Plan:
- Single read, BEAT_W=512: req addr 0x000001000, id 3 -> rd_go 1 cycle with rd_addr 0x000001000; one pop of 0xAB..AB, then rd_done -> one resp beat: id 3, resp_we 0, data 0xAB..AB, last 1.
- Single write: id 5, data 0x55..55 -> wr_go, one wr_en with wr_data 0x55..55; wr_full held 3 cycles delays wr_en 3 cycles; wr_done -> resp_we 1, id 5, last 1.
- Fill ENTRIES=16 with the host stalled -> req_ready drops after the 16th accept; perf_stall_cnt counts stalled cycles; drain returns ids 0..15 in order; pointer wrap verified by 4 extra requests.
- BEAT_W=128 read of addr 0x40 -> 4 beats at addrs 0x40, 0x50, 0x60, 0x70 holding data[127:0]..data[511:384]; resp_ready toggling each cycle holds outputs; last on beat 4 only.
- Mixed R,W,R with random resp_ready -> host order and response order both R,W,R.
- rst asserted during RD_DATA -> next cycle all outputs 0, req_ready 1; a following request issues normally.
